// File: rtl/poly_eval_pkg.sv
// rtl/poly_eval_pkg.sv - state codes, ALU op codes and default widths for the polynomial evaluator
package poly_eval_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 16;

   typedef enum logic [3:0] {
      LOAD_A      = 4'd0,
      LOAD_A_WAIT = 4'd1,
      LOAD_B      = 4'd2,
      LOAD_B_WAIT = 4'd3,
      LOAD_C      = 4'd4,
      LOAD_C_WAIT = 4'd5,
      LOAD_X      = 4'd6,
      LOAD_X_WAIT = 4'd7,
      CYC0        = 4'd8,
      CYC1        = 4'd9,
      CYC2        = 4'd10,
      CYC3        = 4'd11,
      CYC4        = 4'd12,
      DONE        = 4'd13
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      MUL_AX = 3'd1,
      MUL_RX = 3'd2,
      MUL_BX = 3'd3,
      ADD_AB = 3'd4,
      ADD_RC = 3'd5
   } alu_op_t;

   // The op a compute state performs at the edge that ends it.
   function automatic alu_op_t op_for_state(input state_t s);
      case (s)
         CYC0:    return MUL_AX;
         CYC1:    return MUL_RX;
         CYC2:    return MUL_BX;
         CYC3:    return ADD_AB;
         CYC4:    return ADD_RC;
         default: return OP_NOP;
      endcase
   endfunction

   function automatic logic is_compute(input state_t s);
      return (s >= CYC0) && (s <= CYC4);
   endfunction

endpackage

// File: rtl/poly_eval_if.sv
// rtl/poly_eval_if.sv - key/switch input and result/status output bundle of the evaluator
interface poly_eval_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) ();
   logic              go;
   logic [DATA_W-1:0] data_in;
   logic [ACC_W-1:0]  result;
   logic              result_valid;
   logic              busy;
   logic [3:0]        state;
   logic              overflow;

   modport master (
      output go, data_in,
      input  result, result_valid, busy, state, overflow
   );

   modport slave (
      input  go, data_in,
      output result, result_valid, busy, state, overflow
   );
endinterface

// File: rtl/poly_eval_datapath.sv
// rtl/poly_eval_datapath.sv - operand/accumulator registers, shared mul/add, POLY_EVAL_OVF_DETECT_EN overflow flag
module poly_eval_datapath
   import poly_eval_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              ld_a,
   input  logic              ld_b,
   input  logic              ld_c,
   input  logic              ld_x,
   input  alu_op_t           op,
   input  logic [DATA_W-1:0] data_in,
   output logic [ACC_W-1:0]  result,
   output logic              result_valid,
   output logic              overflow
);

   // Full-width arithmetic is only kept when overflow detection needs the carry-out bits.
`ifdef POLY_EVAL_OVF_DETECT_EN
   localparam int MUL_W = 2 * ACC_W;
   localparam int ADD_W = ACC_W + 1;
`else
   localparam int MUL_W = ACC_W;
   localparam int ADD_W = ACC_W;
`endif

   logic [DATA_W-1:0] a_q, b_q, c_q, x_q;
   logic [ACC_W-1:0]  ra_q, rb_q;
   logic [ACC_W-1:0]  mul_l, add_r;
   logic [MUL_W-1:0]  mul_full;
   logic [ADD_W-1:0]  add_full;

   // Operand muxes: multiplier always multiplies by x, adder always adds onto ra.
   always_comb begin
      mul_l = '0;
      add_r = '0;
      case (op)
         MUL_AX:  mul_l = ACC_W'(a_q);
         MUL_RX:  mul_l = ra_q;
         MUL_BX:  mul_l = ACC_W'(b_q);
         ADD_AB:  add_r = rb_q;
         ADD_RC:  add_r = ACC_W'(c_q);
         default: ;
      endcase
   end

   assign mul_full = MUL_W'(mul_l) * MUL_W'(x_q);
   assign add_full = ADD_W'(ra_q) + ADD_W'(add_r);

   // Operand capture, single write-back per compute op, and result hold/clear.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         a_q          <= '0;
         b_q          <= '0;
         c_q          <= '0;
         x_q          <= '0;
         ra_q         <= '0;
         rb_q         <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         if (ld_a) begin
            a_q          <= data_in;
            result_valid <= 1'b0;
         end
         if (ld_b) b_q <= data_in;
         if (ld_c) c_q <= data_in;
         if (ld_x) x_q <= data_in;
         case (op)
            MUL_AX, MUL_RX: ra_q <= mul_full[ACC_W-1:0];
            MUL_BX:         rb_q <= mul_full[ACC_W-1:0];
            ADD_AB:         ra_q <= add_full[ACC_W-1:0];
            ADD_RC: begin
               result       <= add_full[ACC_W-1:0];
               result_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef POLY_EVAL_OVF_DETECT_EN
   logic is_mul, is_add;

   assign is_mul = (op == MUL_AX) || (op == MUL_RX) || (op == MUL_BX);
   assign is_add = (op == ADD_AB) || (op == ADD_RC);

   // Sticky flag: any truncated bits in the active op set it; a new evaluation clears it.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         overflow <= 1'b0;
      end else if (ld_a) begin
         overflow <= 1'b0;
      end else if ((is_mul && (|mul_full[MUL_W-1:ACC_W])) ||
                   (is_add && add_full[ACC_W])) begin
         overflow <= 1'b1;
      end
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: rtl/poly_eval_ctrl.sv
// rtl/poly_eval_ctrl.sv - load/compute sequencer for y = A*x^2 + B*x + C
module poly_eval_ctrl
   import poly_eval_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic       clock,
   input  logic       resetn,
   poly_eval_if.slave bus
);

   state_t  state_q, next_state;
   alu_op_t op_q;
   logic    busy_q;
   logic    ld_a, ld_b, ld_c, ld_x;

   // Captures happen on the go edge itself, so the enables decode the current state directly.
   assign ld_a = (state_q == LOAD_A) && bus.go;
   assign ld_b = (state_q == LOAD_B) && bus.go;
   assign ld_c = (state_q == LOAD_C) && bus.go;
   assign ld_x = (state_q == LOAD_X) && bus.go;

   // Next-state: each LOAD captures once, its WAIT holds until go is released.
   always_comb begin
      next_state = state_q;
      case (state_q)
         LOAD_A:      if (bus.go)  next_state = LOAD_A_WAIT;
         LOAD_A_WAIT: if (!bus.go) next_state = LOAD_B;
         LOAD_B:      if (bus.go)  next_state = LOAD_B_WAIT;
         LOAD_B_WAIT: if (!bus.go) next_state = LOAD_C;
         LOAD_C:      if (bus.go)  next_state = LOAD_C_WAIT;
         LOAD_C_WAIT: if (!bus.go) next_state = LOAD_X;
         LOAD_X:      if (bus.go)  next_state = LOAD_X_WAIT;
         LOAD_X_WAIT: if (!bus.go) next_state = CYC0;
         CYC0:        next_state = CYC1;
         CYC1:        next_state = CYC2;
         CYC2:        next_state = CYC3;
         CYC3:        next_state = CYC4;
         CYC4:        next_state = DONE;
         DONE:        next_state = LOAD_A;
         default:     next_state = LOAD_A;
      endcase
   end

   // State register with busy and op code registered against the state being entered.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= LOAD_A;
         busy_q  <= 1'b0;
         op_q    <= OP_NOP;
      end else begin
         state_q <= next_state;
         busy_q  <= is_compute(next_state);
         op_q    <= op_for_state(next_state);
      end
   end

   assign bus.state = state_q;
   assign bus.busy  = busy_q;

   poly_eval_datapath #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_datapath (
      .clock        (clock),
      .resetn       (resetn),
      .ld_a         (ld_a),
      .ld_b         (ld_b),
      .ld_c         (ld_c),
      .ld_x         (ld_x),
      .op           (op_q),
      .data_in      (bus.data_in),
      .result       (bus.result),
      .result_valid (bus.result_valid),
      .overflow     (bus.overflow)
   );

endmodule

// File: tb/tb_poly_eval_ctrl.sv
// tb/tb_poly_eval_ctrl.sv - scoreboard bench for poly_eval_ctrl
module tb_poly_eval_ctrl;

   typedef struct {
      logic [15:0] res;
      logic        ovf;
   } exp_t;

`ifdef POLY_EVAL_OVF_DETECT_EN
   localparam logic TRUNC_OVF = 1'b1;
`else
   localparam logic TRUNC_OVF = 1'b0;
`endif

   logic clock = 1'b0;
   logic resetn = 1'b0;
   int   pass_cnt = 0;
   int   chk_cnt = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   logic rv_prev = 1'b0;

   poly_eval_if #(.DATA_W(8), .ACC_W(16)) bus ();

   poly_eval_ctrl dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   // Monitor: each completed evaluation is matched against the oldest expectation.
   always @(negedge clock) begin
      if (resetn && bus.result_valid && !rv_prev) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("result", bus.result, mon_e.res);
            check("overflow", bus.overflow, mon_e.ovf);
         end
      end
      rv_prev = bus.result_valid;
   end

   task automatic load_one(input logic [7:0] v, input int hold);
      bus.data_in = v;
      bus.go = 1'b1;
      repeat (hold) @(negedge clock);
      bus.go = 1'b0;
      @(negedge clock);
   endtask

   // Called in CYC0 (one negedge after go released in LOAD_X_WAIT).
   task automatic run_tail(input string tag);
      int busy_n;
      int rv_at;
      int done_at;
      busy_n = 0;
      rv_at = 0;
      done_at = 0;
      for (int k = 1; k <= 7; k++) begin
         if (bus.busy) busy_n++;
         if (bus.result_valid && rv_at == 0) rv_at = k;
         if (bus.state == 4'd13 && done_at == 0) done_at = k;
         @(negedge clock);
      end
      check({tag, "_busy_cycles"}, busy_n, 32'd5);
      check({tag, "_valid_edge"}, rv_at, 32'd6);
      check({tag, "_done_edge"}, done_at, 32'd6);
      check({tag, "_back_to_load_a"}, bus.state, 32'd0);
   endtask

   task automatic run_eval(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] x, input logic [15:0] res, input logic ovf,
                           input string tag);
      load_one(a, 2);
      load_one(b, 2);
      load_one(c, 2);
      sb_q.push_back('{res, ovf});
      load_one(x, 2);
      run_tail(tag);
   endtask

   initial begin
      int bad;
      bus.go = 1'b0;
      bus.data_in = '0;
      resetn = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_state", bus.state, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_valid", bus.result_valid, 32'd0);
      check("rst_busy", bus.busy, 32'd0);
      check("rst_overflow", bus.overflow, 32'd0);
      resetn = 1'b1;
      @(negedge clock);

      // 2*25 + 3*5 + 4 = 69
      run_eval(8'd2, 8'd3, 8'd4, 8'd5, 16'h0045, 1'b0, "basic");

      // Result holds with go low, then a new A capture drops valid but keeps the value.
      bad = 0;
      repeat (20) begin
         if (bus.result_valid !== 1'b1) bad++;
         @(negedge clock);
      end
      check("hold_valid_cycles_bad", bad, 32'd0);
      check("hold_result", bus.result, 32'h0045);
      bus.data_in = 8'd7;
      bus.go = 1'b1;
      @(negedge clock);
      check("clear_valid_on_a", bus.result_valid, 32'd0);
      check("keep_result_on_a", bus.result, 32'h0045);
      check("after_a_state", bus.state, 32'd1);
      @(negedge clock);
      bus.go = 1'b0;
      @(negedge clock);
      // Zero x: 7*0 + 9*0 + 0x21
      load_one(8'd9, 2);
      load_one(8'h21, 2);
      sb_q.push_back('{16'h0021, 1'b0});
      load_one(8'd0, 2);
      run_tail("zero_x");

      // 255s: 0xFE01*0xFF -> 0x02FF, +0xFE01 -> 0x0100, +0xFF -> 0x01FF
      run_eval(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h01FF, TRUNC_OVF, "trunc");

      // Held go: only the first edge captures A.
      bad = 0;
      bus.data_in = 8'h11;
      bus.go = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (bus.state !== 4'd1) bad++;
         bus.data_in = 8'h30 + 8'(i);
      end
      bus.go = 1'b0;
      @(negedge clock);
      check("held_go_state_bad", bad, 32'd0);
      check("held_go_release", bus.state, 32'd2);
      load_one(8'd0, 2);
      load_one(8'd0, 2);
      sb_q.push_back('{16'h0011, 1'b0});
      load_one(8'd1, 2);
      run_tail("held_go");

      // Reset in CYC2 aborts the evaluation and clears everything.
      load_one(8'd3, 2);
      load_one(8'd3, 2);
      load_one(8'd3, 2);
      load_one(8'd3, 2);
      @(negedge clock);
      @(negedge clock);
      check("mid_at_cyc2", bus.state, 32'd10);
      resetn = 1'b0;
      @(negedge clock);
      check("mid_rst_state", bus.state, 32'd0);
      check("mid_rst_result", bus.result, 32'd0);
      check("mid_rst_valid", bus.result_valid, 32'd0);
      check("mid_rst_busy", bus.busy, 32'd0);
      check("mid_rst_overflow", bus.overflow, 32'd0);
      resetn = 1'b1;
      @(negedge clock);
      run_eval(8'd1, 8'd1, 8'd1, 8'd1, 16'h0003, 1'b0, "after_rst");

      repeat (3) @(negedge clock);
      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/poly_eval_ctrl.md
# poly_eval_ctrl

Sequenced evaluator for y = A·x² + B·x + C over operands entered one at a time on a shared data bus. It combines a control FSM with a small datapath that time-shares one multiplier and one adder across five compute cycles. It sits behind the switch/key input layer: `go` is a debounced, active-high key and `data_in` comes from switches. It drives result and state LEDs/hex displays.

## Interface
- DATA_W, 8, operand width (A, B, C, x)
- ACC_W, 16, accumulator/result width; all intermediates truncated to ACC_W
- clock  in  1  system clock, rising-edge
- resetn  in  1  reset, synchronous, active-low; clock clock
- go  in  1  level input: load/advance request
- data_in  in  DATA_W  operand bus, sampled only on load captures
- result  out  ACC_W  final y, registered
- result_valid  out  1  result holds a completed evaluation
- busy  out  1  high in compute states
- state  out  4  current FSM encoding, for debug LEDs
- overflow  out  1  sticky truncation flag (see Configuration)

## Operation
- The FSM has 14 states. Load states are LOAD_A, LOAD_A_WAIT, LOAD_B, LOAD_B_WAIT, LOAD_C, LOAD_C_WAIT, LOAD_X and LOAD_X_WAIT. Compute states are CYC0 to CYC4. DONE is the final state.
- **LOAD_n:** when go=1 at an edge, capture data_in (zero-extended) into reg n, then go to LOAD_n_WAIT. Otherwise stay.
- **LOAD_n_WAIT:** stay while go=1. When go=0, go to the next LOAD state; LOAD_X_WAIT goes to CYC0.
  - Holding go high therefore captures exactly once.
- **Compute schedule** (one ALU op per cycle; ra and rb are ACC_W registers):
  - CYC0: ra ← A·x
  - CYC1: ra ← ra·x
  - CYC2: rb ← B·x
  - CYC3: ra ← ra + rb
  - CYC4: result ← ra + C, and result_valid ← 1
- In each compute cycle, exactly one of the multiplier or adder outputs is written. Inputs are selected by a 3-bit op code issued by the FSM.
- **DONE:** go to LOAD_A unconditionally on the next edge.
- result and result_valid hold until the next capture into A. That capture clears result_valid; result keeps its old value until the next CYC4.
- go is ignored in CYC0 to CYC4 and in DONE.
- **Arithmetic:** products and sums are unsigned. Each is truncated to its low ACC_W bits.

## Timing
- **Reset:** resetn=0 at any edge, including mid-compute, gives the following at that edge:
  - state=LOAD_A
  - A, B, C, x, ra, rb, result all 0
  - result_valid=0, busy=0, overflow=0
- **Latency:** let E be the edge where go=0 is sampled in LOAD_X_WAIT. CYC0 runs during E→E+1. result/result_valid update at edge E+5. state=LOAD_A after E+6.
- busy=1 exactly while state ∈ {CYC0..CYC4}, registered-state decode.
- **Minimum full operation:** 8 load edges plus 6, i.e. 14 edges.
- **State encoding:** LOAD_A=0, LOAD_A_WAIT=1, and so on through LOAD_X_WAIT=7; CYC0..CYC4=8..12; DONE=13. Codes 14 and 15 go to LOAD_A.

## Configuration
- Macro: POLY_EVAL_OVF_DETECT_EN.
- **Defined:** overflow is set at any compute edge where the untruncated product or sum exceeds 2^ACC_W−1.
  - It stays set through DONE.
  - It clears on capture into A or on reset.
- **Undefined:** overflow is tied to 0 and no detection logic is built. The port still exists.

## Structure
- Package poly_eval_pkg contains:
  - state encoding constants
  - ALU op-code constants (MUL_AX, MUL_RX, MUL_BX, ADD_AB, ADD_RC)
  - default DATA_W and ACC_W
- Sub-module poly_eval_datapath contains the A/B/C/x/ra/rb/result registers, the single multiplier and adder, the operand muxes and the overflow logic. It takes load enables and an op code.
- The top poly_eval_ctrl holds the FSM and instantiates the datapath.

## Test plan
- **Basic evaluation:** A=2, B=3, C=4, x=5, each go pulse 2 cycles → result=0x0045, result_valid at E+5, busy high exactly 5 cycles.
- **Zero x:** A=7, B=9, C=0x21, x=0 → result=0x0021, overflow=0.
- **Truncation:** A=B=C=x=255 → result=0x01FF.
  - With macro: overflow=1.
  - Without macro: overflow=0.
- **Held go:** go held 10 cycles in LOAD_A with data_in changing → A equals data_in at the first edge, state=LOAD_A_WAIT throughout.
- **Mid-compute reset:** resetn=0 during CYC2 → the next state is 0, result=0, result_valid=0. A fresh load of 1,1,1,1 → result=0x0003.
- **Result hold and clear:** after done, result_valid stays 1 with go low for 20 cycles. Capturing a new A drops result_valid the same edge while result keeps its prior value.
